// File: rtl/fma16_sched_pkg.sv
// Shared types and constants for the fp16 FMA scheduler.
//   fp16_t      : raw IEEE half-precision bit pattern
//   fma16_op_t  : per-request op bundle {mul, add, negr, negz, roundmode}
//   Rm*         : roundmode encodings understood by fma16
package fma16_sched_pkg;

  localparam int unsigned DefaultNreq = 4;

  typedef logic [15:0] fp16_t;

  // mul=0 passes x through unmultiplied; add=0 drops z; negz negates z; negr negates the result.
  typedef struct packed {
    logic       mul;
    logic       add;
    logic       negr;
    logic       negz;
    logic [1:0] roundmode;
  } fma16_op_t;

  localparam logic [1:0] RmRne = 2'd0;  // nearest, ties to even
  localparam logic [1:0] RmRtz = 2'd1;  // toward zero
  localparam logic [1:0] RmRdn = 2'd2;  // toward -inf
  localparam logic [1:0] RmRup = 2'd3;  // toward +inf

endpackage

// File: rtl/fma16.sv
// Combinational half-precision fused multiply-add: r = +/-((mul ? x*y : x) + (add ? +/-z : 0)).
// Ports: x_i, y_i, z_i operands; op_i op bundle; result_o single-rounded fp16 result.
// The sum is formed exactly in an 84-bit fixed-point accumulator (LSB = 2^-50), so a single
// rounding step at the end gives a true fused result with no alignment sticky logic.
module fma16
  import fma16_sched_pkg::*;
(
  input  fp16_t     x_i,
  input  fp16_t     y_i,
  input  fp16_t     z_i,
  input  fma16_op_t op_i,
  output fp16_t     result_o
);

  localparam int unsigned AccW = 84;

  logic [10:0] sig_x, sig_y, sig_z;
  logic [5:0]  exp_x, exp_y, exp_z;
  logic        inf_x, inf_y, inf_z, nan_x, nan_y, nan_z, zero_x, zero_y;

  // Subnormals use exponent 1 with no hidden bit.
  assign sig_x  = {|x_i[14:10], x_i[9:0]};
  assign sig_y  = {|y_i[14:10], y_i[9:0]};
  assign sig_z  = {|z_i[14:10], z_i[9:0]};
  assign exp_x  = (x_i[14:10] == 5'd0) ? 6'd1 : {1'b0, x_i[14:10]};
  assign exp_y  = (y_i[14:10] == 5'd0) ? 6'd1 : {1'b0, y_i[14:10]};
  assign exp_z  = (z_i[14:10] == 5'd0) ? 6'd1 : {1'b0, z_i[14:10]};
  assign inf_x  = (&x_i[14:10]) && (x_i[9:0] == 10'd0);
  assign inf_y  = (&y_i[14:10]) && (y_i[9:0] == 10'd0);
  assign inf_z  = (&z_i[14:10]) && (z_i[9:0] == 10'd0);
  assign nan_x  = (&x_i[14:10]) && (x_i[9:0] != 10'd0);
  assign nan_y  = (&y_i[14:10]) && (y_i[9:0] != 10'd0);
  assign nan_z  = (&z_i[14:10]) && (z_i[9:0] != 10'd0);
  assign zero_x = (x_i[14:0] == 15'd0);
  assign zero_y = (y_i[14:0] == 15'd0);

  logic            sign_a, sign_b, sign_r, sign_f;
  logic [21:0]     prod;
  logic [AccW-1:0] mag_a, mag_b, mag, mask;
  logic [6:0]      lead, lsb;
  logic [10:0]     kept;
  logic            guard, sticky, inc, to_max, is_nan, inf_a, inf_b;
  logic [16:0]     total;

  always_comb begin
    prod   = 22'(sig_x) * 22'(sig_y);
    sign_a = op_i.mul ? (x_i[15] ^ y_i[15]) : x_i[15];
    sign_b = op_i.add ? (z_i[15] ^ op_i.negz) : sign_a;
    mag_a  = op_i.mul ? (AccW'(prod) << (7'(exp_x) + 7'(exp_y)))
                      : (AccW'(sig_x) << (7'(exp_x) + 7'd25));
    mag_b  = op_i.add ? (AccW'(sig_z) << (7'(exp_z) + 7'd25)) : '0;

    if (sign_a == sign_b) begin
      mag    = mag_a + mag_b;
      sign_r = sign_a;
    end else if (mag_a >= mag_b) begin
      mag    = mag_a - mag_b;
      sign_r = sign_a;
    end else begin
      mag    = mag_b - mag_a;
      sign_r = sign_b;
    end
    // Exact cancellation gives +0 except when rounding toward -inf.
    if ((mag == '0) && (sign_a != sign_b)) sign_r = (op_i.roundmode == RmRdn);
    sign_f = sign_r ^ op_i.negr;

    lead = '0;
    for (int i = 0; i < AccW; i++) begin
      if (mag[i]) lead = 7'(i);
    end
    // Bit 26 is the subnormal LSB (2^-24); normals keep 11 bits below the leading one.
    lsb    = (lead >= 7'd36) ? lead - 7'd10 : 7'd26;
    kept   = 11'(mag >> lsb);
    guard  = mag[lsb - 7'd1];
    mask   = (AccW'(1) << (lsb - 7'd1)) - AccW'(1);
    sticky = |(mag & mask);

    case (op_i.roundmode)
      RmRne:   inc = guard & (sticky | kept[0]);
      RmRtz:   inc = 1'b0;
      RmRdn:   inc = sign_f & (guard | sticky);
      default: inc = !sign_f & (guard | sticky);
    endcase

    // Hidden bit carries into the exponent field, so round-up overflow needs no special case.
    total  = (17'(lsb - 7'd26) << 10) + 17'(kept) + 17'(inc);
    to_max = (op_i.roundmode == RmRtz) || ((op_i.roundmode == RmRdn) && !sign_f) ||
             ((op_i.roundmode == RmRup) && sign_f);

    inf_a  = inf_x | (op_i.mul & inf_y);
    inf_b  = op_i.add & inf_z;
    is_nan = nan_x | (op_i.mul & nan_y) | (op_i.add & nan_z) |
             (op_i.mul & ((inf_x & zero_y) | (inf_y & zero_x))) |
             (inf_a & inf_b & (sign_a != sign_b));

    if (is_nan)                    result_o = 16'h7E00;
    else if (inf_a)                result_o = {sign_a ^ op_i.negr, 15'h7C00};
    else if (inf_b)                result_o = {sign_b ^ op_i.negr, 15'h7C00};
    else if (total >= 17'h07C00)   result_o = {sign_f, to_max ? 15'h7BFF : 15'h7C00};
    else                           result_o = {sign_f, total[14:0]};
  end

endmodule

// File: rtl/fma16_sched_rr_arbiter.sv
// Round-robin arbiter: grants the first asserted req at or above ptr, wrapping N-1 -> 0.
// Ports: req request vector; ptr search start; grant one-hot grant; idx encoded grant index.
module rr_arbiter #(
  parameter  int unsigned N    = 4,
  localparam int unsigned IdxW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [IdxW-1:0] ptr,
  output logic [N-1:0]    grant,
  output logic [IdxW-1:0] idx
);

  always_comb begin
    int unsigned cand;
    logic        found;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = int'(ptr) + k;
      if (cand >= N) cand = cand - N;
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = IdxW'(cand);
      end
    end
  end

endmodule

// File: rtl/fma16_sched.sv
// Shares one combinational fma16 among NREQ requesters through a two-stage pipeline
// (S1 operand register -> fma16 -> S2 result register) with round-robin admission.
// Ports: clk, reset (sync, active-low); req_valid/req_ready plus flattened req_x/y/z (16b each)
// and req_op (6b each) per requester; rsp_valid/rsp_ready with rsp_id and rsp_result;
// ops_done counts response transfers modulo 2^16.
module fma16_sched
  import fma16_sched_pkg::*;
#(
  parameter  int unsigned NREQ = DefaultNreq,
  localparam int unsigned IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*16-1:0] req_x,
  input  logic [NREQ*16-1:0] req_y,
  input  logic [NREQ*16-1:0] req_z,
  input  logic [NREQ*6-1:0] req_op,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [15:0]       rsp_result,
  output logic [15:0]       ops_done
);

  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  gnt_idx;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic            s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
  logic [IDW-1:0]  s1_id_q, s1_id_d, s2_id_q, s2_id_d;
  fp16_t           s1_x_q, s1_x_d, s1_y_q, s1_y_d, s1_z_q, s1_z_d;
  fp16_t           s2_res_q, s2_res_d, fma_res;
  fma16_op_t       s1_op_q, s1_op_d;
  logic [15:0]     ops_q, ops_d;
  logic            s1_free, s2_free, accept, rsp_fire;

  rr_arbiter #(.N(NREQ)) u_arb (
    .req   (req_valid),
    .ptr   (ptr_q),
    .grant (grant),
    .idx   (gnt_idx)
  );

  fma16 u_fma (
    .x_i      (s1_x_q),
    .y_i      (s1_y_q),
    .z_i      (s1_z_q),
    .op_i     (s1_op_q),
    .result_o (fma_res)
  );

  assign s2_free  = !s2_valid_q || rsp_ready;
  assign s1_free  = !s1_valid_q || s2_free;
  // Nothing is offered while reset is asserted, since that edge would discard the accept.
  assign req_ready = grant & {NREQ{s1_free & reset}};
  assign accept   = |req_ready;
  assign rsp_fire = s2_valid_q && rsp_ready;

  always_comb begin
    ptr_d      = ptr_q;
    s1_valid_d = s1_valid_q && !s2_free;
    s1_id_d    = s1_id_q;
    s1_x_d     = s1_x_q;
    s1_y_d     = s1_y_q;
    s1_z_d     = s1_z_q;
    s1_op_d    = s1_op_q;
    s2_valid_d = s2_valid_q;
    s2_id_d    = s2_id_q;
    s2_res_d   = s2_res_q;
    ops_d      = ops_q;

    if (accept) begin
      s1_valid_d = 1'b1;
      s1_id_d    = gnt_idx;
      s1_x_d     = req_x[16*gnt_idx +: 16];
      s1_y_d     = req_y[16*gnt_idx +: 16];
      s1_z_d     = req_z[16*gnt_idx +: 16];
      s1_op_d    = fma16_op_t'(req_op[6*gnt_idx +: 6]);
      ptr_d      = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
    end

    if (s2_free) s2_valid_d = s1_valid_q;
    if (s2_free && s1_valid_q) begin
      s2_id_d  = s1_id_q;
      s2_res_d = fma_res;
    end

    if (rsp_fire) ops_d = ops_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr_q      <= '0;
      s1_valid_q <= 1'b0;
      s1_id_q    <= '0;
      s1_x_q     <= '0;
      s1_y_q     <= '0;
      s1_z_q     <= '0;
      s1_op_q    <= '0;
      s2_valid_q <= 1'b0;
      s2_id_q    <= '0;
      s2_res_q   <= '0;
      ops_q      <= '0;
    end else begin
      ptr_q      <= ptr_d;
      s1_valid_q <= s1_valid_d;
      s1_id_q    <= s1_id_d;
      s1_x_q     <= s1_x_d;
      s1_y_q     <= s1_y_d;
      s1_z_q     <= s1_z_d;
      s1_op_q    <= s1_op_d;
      s2_valid_q <= s2_valid_d;
      s2_id_q    <= s2_id_d;
      s2_res_q   <= s2_res_d;
      ops_q      <= ops_d;
    end
  end

  assign rsp_valid  = s2_valid_q;
  assign rsp_id     = s2_id_q;
  assign rsp_result = s2_res_q;
  assign ops_done   = ops_q;

endmodule

// File: doc/fma16_sched.md
# fma16_sched

Shared-access scheduler for the combinational half-precision fused multiply-add unit `fma16`. Up to NREQ requesters present operand/opcode bundles over valid/ready. A round-robin arbiter grants one per cycle into a two-stage registered pipeline (operand register → `fma16` → result register), and returns each result tagged with the requester ID. It sits between the requester blocks and the single `fma16` instance, so an expensive FMA datapath can be shared without multicycle paths.

## Interface
- NREQ, 4: number of requesters, 2..16
- IDW, $clog2(NREQ): requester ID width (derived, not overridden)
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-low reset
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester accept; at most one bit high per cycle
- req_x, req_y, req_z  in  NREQ*16 each  flattened fp16 operands; requester i at [16i+15:16i]
- req_op  in  NREQ*6  flattened op bundle {mul, add, negr, negz, roundmode[1:0]}; requester i at [6i+5:6i]
- rsp_valid  out  1  result valid
- rsp_ready  in  1  consumer accept
- rsp_id  out  IDW  requester index of the result
- rsp_result  out  16  `fma16` result
- ops_done  out  16  count of completed responses, wraps modulo 2^16

## Operation
- Accept on requester i: `req_valid[i] & req_ready[i]` at a rising edge. Response transfer: `rsp_valid & rsp_ready`.
- Pipeline has two stages:
  - S1 holds the operand register plus ID.
  - S2 holds the result register plus ID.
  - `fma16` sits combinationally between S1 and S2.
- Advance conditions:
  - `s2_free = !s2_valid | rsp_ready`.
  - `s1_free = !s1_valid | s2_free`.
  - S1 moves to S2 when `s1_valid & s2_free`.
  - S1 loads on any accept.
- Arbitration:
  - Grant goes to the first asserted `req_valid` searching upward from `rr_ptr`, wrapping NREQ-1 → 0.
  - `req_ready = grant & {NREQ{s1_free}}`.
  - `req_ready` must not depend on the requester's own valid beyond grant selection.
- Pointer update:
  - On accept of requester g: `rr_ptr <= (g+1) mod NREQ`.
  - Without an accept, the pointer is held.
- Backpressure: while `rsp_valid & !rsp_ready`, `rsp_id`/`rsp_result` are held stable. S1, if full, is also held. All `req_ready` are 0.
- `ops_done` increments on each response transfer.
- Reset values: `req_ready`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_result`=0, `ops_done`=0, `rr_ptr`=0, S1/S2 valid=0.

## Timing
- Latency: accept at edge t → `rsp_valid` high during cycle t+2 when there is no stall.
- Throughput: one op per cycle sustained.
- Boundary cases:
  - No `req_valid`: nothing loads. S1 may still drain into S2.
  - S1 and S2 full with `rsp_ready`=1: at the same edge, S2 is consumed, S1 moves to S2, and a new accept loads S1.
  - S1 and S2 full with `rsp_ready`=0: full stall. Nothing is lost or duplicated.
  - Pointer wrap: grant at NREQ-1 sets `rr_ptr` to 0.
  - `reset` low at any edge, including mid-operation: all in-flight ops are discarded. All outputs take reset values in the following cycle. Flushed ops are never returned.
- `req_*` inputs are sampled only on the accept edge. Requesters hold them while valid and not ready.

## Structure
- Package `fma16_sched_pkg` contains:
  - `fma16_op_t` packed struct {mul, add, negr, negz, roundmode[1:0]}.
  - `fp16_t` typedef as `logic [15:0]`.
  - Default NREQ constant.
- Sub-module `rr_arbiter` (parameter N) contains:
  - Inputs: `req`, `ptr`.
  - Output: one-hot `grant` and encoded index.
  - Purely combinational.
- The top instantiates `rr_arbiter` and one `fma16`, and holds the pointer, S1/S2 registers, and counter.

## Test plan
- Single request: `req_valid[0]`=1, x=16'h3C00, y=16'h4000, z=16'h3C00, op={1,1,0,0,2'b00}. Expect `req_ready[0]`=1 in the same cycle, then two cycles later `rsp_valid`=1, `rsp_id`=0, `rsp_result`=16'h4200, and `ops_done`=1 after transfer.
- All four requesters valid continuously with `rsp_ready`=1:
  - Grants go 0,1,2,3,0,1,… one per cycle.
  - `rsp_id` follows the same order two cycles later.
  - Each result matches a standalone `fma16` reference instance.
- Pointer skip: grant to 2, then only requesters 1 and 3 valid → 3 is granted next, then 1.
- Backpressure: continuous requests with `rsp_ready`=0 for 5 cycles.
  - Exactly 2 accepts occur, then `req_ready`=0.
  - `rsp_result`/`rsp_id` stay stable.
  - After release, responses arrive in accept order with no loss or duplication.
- Mid-operation reset: two ops in flight, `reset`=0 for one cycle.
  - Next cycle: `rsp_valid`=0, `ops_done`=0, `rr_ptr`=0.
  - No response for the flushed ops.
  - The first grant after reset goes to the lowest valid requester.
- Counter wrap: preload via 65536 transfers → `ops_done` returns to 0.
